// File: rtl/envelope_gen.sv
// ADSR amplitude envelope: gates on keycode != 0, scales samples around midscale 128.
// Optional ENV_RETRIGGER_EN: a nonzero-to-nonzero key change restarts the attack from 0.
module envelope_gen #(
  parameter int unsigned TICK_DIV     = 16,
  parameter int unsigned ATTACK_STEP  = 4,
  parameter int unsigned DECAY_STEP   = 2,
  parameter int unsigned SUSTAIN_LVL  = 160,
  parameter int unsigned RELEASE_STEP = 1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en,
  input  logic [3:0] keycode,
  input  logic       sample_now,
  input  logic [7:0] sample_i,
  output logic [7:0] sample_o,
  output logic [7:0] env_level,
  output logic       active
);

  localparam int unsigned     PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [8:0]      ATK_9   = 9'(ATTACK_STEP);
  localparam logic [8:0]      DEC_9   = 9'(DECAY_STEP);
  localparam logic [8:0]      REL_9   = 9'(RELEASE_STEP);
  localparam logic [8:0]      SUS_9   = 9'(SUSTAIN_LVL);
  localparam logic [7:0]      SUS_8   = 8'(SUSTAIN_LVL);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t             state_r, state_nx_s;
  logic [7:0]         level_r, level_nx_s;
  logic [PRE_W-1:0]   pre_r, pre_nx_s;
  logic [3:0]         key_r;
  logic               tick_s, gate_s, retrig_s;
  logic [8:0]         atk_sum_s, dec_dif_s, rel_dif_s;
  logic signed [17:0] samp_ext_s, lvl_ext_s, prod_s;
  logic [7:0]         scaled_s;
  logic               unused_prod_s;

  assign gate_s    = (keycode != 4'd0);
  assign atk_sum_s = {1'b0, level_r} + ATK_9;
  assign dec_dif_s = {1'b0, level_r} - DEC_9;
  assign rel_dif_s = {1'b0, level_r} - REL_9;

`ifdef ENV_RETRIGGER_EN
  assign retrig_s = (key_r != 4'd0) && gate_s && (keycode != key_r);
`else
  logic unused_key_s;
  assign unused_key_s = ^key_r;
  assign retrig_s     = 1'b0;
`endif

  // Prescaler: counts sample_now strobes and emits one tick every TICK_DIV of them.
  always_comb begin
    pre_nx_s = pre_r;
    tick_s   = 1'b0;
    if (en && sample_now) begin
      if (pre_r == PRE_MAX) begin
        tick_s   = 1'b1;
        pre_nx_s = '0;
      end else begin
        pre_nx_s = pre_r + PRE_W'(1);
      end
    end else begin
      pre_nx_s = pre_r;
    end
  end

  // Envelope FSM: gate/retrigger changes take precedence over any level step.
  always_comb begin
    state_nx_s = state_r;
    level_nx_s = level_r;
    if (!en) begin
      state_nx_s = state_r;
      level_nx_s = level_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          level_nx_s = 8'd0;
          if (gate_s) state_nx_s = ST_ATTACK;
          else        state_nx_s = ST_IDLE;
        end
        ST_ATTACK: begin
          if (!gate_s) begin
            state_nx_s = ST_RELEASE;
          end else if (retrig_s) begin
            state_nx_s = ST_ATTACK;
            level_nx_s = 8'd0;
          end else if (level_r == 8'd255) begin
            state_nx_s = ST_DECAY;
          end else if (tick_s) begin
            if (atk_sum_s >= 9'd255) begin
              level_nx_s = 8'd255;
              state_nx_s = ST_DECAY;
            end else begin
              level_nx_s = atk_sum_s[7:0];
            end
          end else begin
            level_nx_s = level_r;
          end
        end
        ST_DECAY: begin
          if (!gate_s) begin
            state_nx_s = ST_RELEASE;
          end else if (retrig_s) begin
            state_nx_s = ST_ATTACK;
            level_nx_s = 8'd0;
          end else if (level_r <= SUS_8) begin
            // Also covers SUSTAIN_LVL = 255, where decay has nothing to do.
            level_nx_s = SUS_8;
            state_nx_s = ST_SUSTAIN;
          end else if (tick_s) begin
            if (dec_dif_s[8] || (dec_dif_s <= SUS_9)) begin
              level_nx_s = SUS_8;
              state_nx_s = ST_SUSTAIN;
            end else begin
              level_nx_s = dec_dif_s[7:0];
            end
          end else begin
            level_nx_s = level_r;
          end
        end
        ST_SUSTAIN: begin
          if (!gate_s) begin
            state_nx_s = ST_RELEASE;
          end else if (retrig_s) begin
            state_nx_s = ST_ATTACK;
            level_nx_s = 8'd0;
          end else begin
            level_nx_s = SUS_8;
          end
        end
        ST_RELEASE: begin
          if (gate_s) begin
            state_nx_s = ST_ATTACK;
          end else if (level_r == 8'd0) begin
            state_nx_s = ST_IDLE;
          end else if (tick_s) begin
            if (rel_dif_s[8] || (rel_dif_s == 9'd0)) begin
              level_nx_s = 8'd0;
              state_nx_s = ST_IDLE;
            end else begin
              level_nx_s = rel_dif_s[7:0];
            end
          end else begin
            level_nx_s = level_r;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          level_nx_s = 8'd0;
        end
      endcase
    end
  end

  // Arithmetic shift floors, so at full level sample 255 maps to 254 and sample 0 to 0.
  assign samp_ext_s    = $signed({10'd0, sample_i}) - 18'sd128;
  assign lvl_ext_s     = $signed({10'd0, level_r});
  assign prod_s        = samp_ext_s * lvl_ext_s;
  assign scaled_s      = 8'd128 + prod_s[15:8];
  assign unused_prod_s = ^{prod_s[17:16], prod_s[7:0]};

  // State, level, prescaler, stored key and output sample registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r  <= ST_IDLE;
      level_r  <= 8'd0;
      pre_r    <= '0;
      key_r    <= 4'd0;
      sample_o <= 8'd128;
    end else begin
      state_r <= state_nx_s;
      level_r <= level_nx_s;
      pre_r   <= pre_nx_s;
      if (en) begin
        key_r    <= keycode;
        sample_o <= scaled_s;
      end else begin
        key_r    <= key_r;
        sample_o <= 8'd128;
      end
    end
  end

  assign env_level = level_r;
  assign active    = (state_r != ST_IDLE);

endmodule

// File: tb/tb_envelope_gen.sv
// Scoreboard bench for envelope_gen: two instances (TICK_DIV 1 and 3) against an ADSR reference model.
module tb_envelope_gen;

  localparam int AS = 4, DS = 2, SL = 160, RS = 1;
  localparam int P_IDLE = 0, P_ATK = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;
`ifdef ENV_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       en = 1'b0;
  logic       sample_now = 1'b0;
  logic [3:0] keycode = 4'd0;
  logic [7:0] sample_i = 8'd128;
  logic [7:0] so_w [2];
  logic [7:0] lv_w [2];
  logic       act_w [2];

  always #5 clk = ~clk;

  envelope_gen #(.TICK_DIV(1)) dut0 (
    .clk(clk), .n_rst(n_rst), .en(en), .keycode(keycode), .sample_now(sample_now),
    .sample_i(sample_i), .sample_o(so_w[0]), .env_level(lv_w[0]), .active(act_w[0]));

  envelope_gen #(.TICK_DIV(3)) dut1 (
    .clk(clk), .n_rst(n_rst), .en(en), .keycode(keycode), .sample_now(sample_now),
    .sample_i(sample_i), .sample_o(so_w[1]), .env_level(lv_w[1]), .active(act_w[1]));

  typedef struct {
    int so[2];
    int lv[2];
    int act[2];
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;
  int td[2] = '{1, 3};
  int m_ph[2], m_lv[2], m_pre[2];
  int m_key = 0;
  logic [3:0] cur_key;
  int frozen;

  task automatic chk(input string nm, input logic [7:0] act, input int exp);
    tests++;
    if (act !== 8'(exp)) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_bound(input string nm, input bit ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: stimulus bound expired at %0t", nm, $time);
    end
  endtask

  function automatic int floor256(input int p);
    int r;
    r = p % 256;
    if (r < 0) r += 256;
    return (p - r) / 256;
  endfunction

  // Reference ADSR model: advances one clock and returns the outputs seen after that edge.
  task automatic model_step(input logic r, input logic e, input logic [3:0] k,
                            input logic sn, input logic [7:0] s, output exp_t x);
    bit tick, gate, rt;
    for (int i = 0; i < 2; i++) begin
      if (!r) begin
        m_ph[i] = P_IDLE; m_lv[i] = 0; m_pre[i] = 0; x.so[i] = 128;
      end else if (!e) begin
        x.so[i] = 128;
      end else begin
        x.so[i] = (128 + floor256((int'(s) - 128) * m_lv[i])) & 255;
        tick = 1'b0;
        if (sn) begin
          if (m_pre[i] == td[i] - 1) begin tick = 1'b1; m_pre[i] = 0; end
          else m_pre[i]++;
        end
        gate = (k != 4'd0);
        rt = RETRIG && (m_key != 0) && gate && (int'(k) != m_key);
        case (m_ph[i])
          P_IDLE: begin
            m_lv[i] = 0;
            if (gate) m_ph[i] = P_ATK;
          end
          P_ATK, P_DEC, P_SUS: begin
            if (!gate) m_ph[i] = P_REL;
            else if (rt) begin m_ph[i] = P_ATK; m_lv[i] = 0; end
            else if (m_ph[i] == P_ATK) begin
              if (m_lv[i] == 255) m_ph[i] = P_DEC;
              else if (tick) begin
                m_lv[i] = (m_lv[i] + AS > 255) ? 255 : m_lv[i] + AS;
                if (m_lv[i] == 255) m_ph[i] = P_DEC;
              end
            end else if (m_ph[i] == P_DEC) begin
              if (m_lv[i] <= SL) begin m_lv[i] = SL; m_ph[i] = P_SUS; end
              else if (tick) begin
                m_lv[i] = (m_lv[i] - DS < SL) ? SL : m_lv[i] - DS;
                if (m_lv[i] == SL) m_ph[i] = P_SUS;
              end
            end else m_lv[i] = SL;
          end
          P_REL: begin
            if (gate) m_ph[i] = P_ATK;
            else if (m_lv[i] == 0) m_ph[i] = P_IDLE;
            else if (tick) begin
              m_lv[i] = (m_lv[i] - RS < 0) ? 0 : m_lv[i] - RS;
              if (m_lv[i] == 0) m_ph[i] = P_IDLE;
            end
          end
          default: m_ph[i] = P_IDLE;
        endcase
      end
      x.lv[i]  = m_lv[i];
      x.act[i] = (m_ph[i] != P_IDLE) ? 1 : 0;
    end
    if (!r) m_key = 0;
    else if (e) m_key = int'(k);
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] k,
                      input logic sn, input logic [7:0] s);
    exp_t x;
    n_rst = r; en = e; keycode = k; sample_now = sn; sample_i = s;
    model_step(r, e, k, sn, s, x);
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every cycle's outputs against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("sample_o[%0d]", i), so_w[i], mon_e.so[i]);
        chk($sformatf("env_level[%0d]", i), lv_w[i], mon_e.lv[i]);
        chk($sformatf("active[%0d]", i), {7'd0, act_w[i]}, mon_e.act[i]);
      end
    end
  end

  function automatic logic [7:0] rnd8();
    return 8'($urandom_range(255, 0));
  endfunction

  initial begin
    // Reset with a key held.
    step(1'b0, 1'b1, 4'd5, 1'b1, 8'd255);
    step(1'b0, 1'b1, 4'd5, 1'b1, 8'd255);
    chk("reset_sample_o", so_w[0], 128);
    chk("reset_level", lv_w[0], 0);
    chk("reset_active", {7'd0, act_w[0]}, 0);

    // Attack up to full scale, then let it settle into sustain.
    for (int n = 0; n < 200 && m_lv[0] != 255; n++) step(1'b1, 1'b1, 4'd3, 1'b1, 8'd255);
    chk_bound("attack_reach_255", m_lv[0] == 255);
    step(1'b1, 1'b1, 4'd3, 1'b1, 8'd255);
    chk("full_scale_sample", so_w[0], 254);
    for (int n = 0; n < 1000 && !(m_ph[0] == P_SUS && m_ph[1] == P_SUS); n++)
      step(1'b1, 1'b1, 4'd3, 1'b1, rnd8());
    chk_bound("reach_sustain", m_ph[0] == P_SUS && m_ph[1] == P_SUS);
    chk("sustain_level0", lv_w[0], SL);
    chk("sustain_level1", lv_w[1], SL);

    // Release to idle.
    for (int n = 0; n < 2000 && !(m_ph[0] == P_IDLE && m_ph[1] == P_IDLE); n++)
      step(1'b1, 1'b1, 4'd0, 1'b1, rnd8());
    chk_bound("release_to_idle", m_ph[0] == P_IDLE && m_ph[1] == P_IDLE);
    chk("idle_active", {7'd0, act_w[1]}, 0);

    // Gate fall coinciding with a tick at level 100.
    for (int n = 0; n < 200 && !(m_ph[0] == P_ATK && m_lv[0] == 100); n++)
      step(1'b1, 1'b1, 4'd3, 1'b1, rnd8());
    chk_bound("attack_reach_100", m_lv[0] == 100);
    step(1'b1, 1'b1, 4'd0, 1'b1, rnd8());
    chk("collision_level", lv_w[0], 100);
    for (int n = 0; n < 2000 && !(m_ph[0] == P_IDLE && m_ph[1] == P_IDLE); n++)
      step(1'b1, 1'b1, 4'd0, 1'b1, rnd8());

    // Enable low for 50 clocks mid-decay.
    for (int n = 0; n < 400 && !(m_ph[0] == P_DEC && m_lv[0] <= 200); n++)
      step(1'b1, 1'b1, 4'd3, 1'b1, rnd8());
    chk_bound("reach_decay", m_ph[0] == P_DEC);
    frozen = m_lv[0];
    for (int n = 0; n < 50; n++) step(1'b1, 1'b0, 4'd3, 1'($urandom_range(1, 0)), rnd8());
    chk("en_low_level", lv_w[0], frozen);
    chk("en_low_sample", so_w[0], 128);
    for (int n = 0; n < 100; n++) step(1'b1, 1'b1, 4'd3, 1'b1, rnd8());

    // Key change 3 -> 7 in sustain.
    for (int n = 0; n < 2000 && !(m_ph[0] == P_SUS && m_ph[1] == P_SUS); n++)
      step(1'b1, 1'b1, 4'd3, 1'b1, rnd8());
    chk_bound("reach_sustain_2", m_ph[0] == P_SUS && m_ph[1] == P_SUS);
    step(1'b1, 1'b1, 4'd7, 1'b1, rnd8());
    chk("retrigger_level", lv_w[0], RETRIG ? 0 : SL);
    for (int n = 0; n < 10; n++) step(1'b1, 1'b1, 4'd7, 1'b1, rnd8());
    for (int n = 0; n < 20; n++) step(1'b1, 1'b1, 4'd0, 1'b1, rnd8());
    for (int n = 0; n < 30; n++) step(1'b1, 1'b1, 4'd5, 1'b1, rnd8());
    for (int n = 0; n < 2000 && !(m_ph[0] == P_IDLE && m_ph[1] == P_IDLE); n++)
      step(1'b1, 1'b1, 4'd0, 1'b1, rnd8());

    // Randomized traffic: held keys, sporadic strobes, enable drops and resets.
    cur_key = 4'd0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(59, 0) == 0)
        cur_key = ($urandom_range(2, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
      step(1'($urandom_range(299, 0) != 0), 1'($urandom_range(15, 0) != 0), cur_key,
           1'($urandom_range(1, 0)), rnd8());
    end

    repeat (2) @(negedge clk);
    chk_bound("scoreboard_drained", exp_q.size() == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
